// File: rtl/ppwm_prog_mem.sv
// Program store for one PWM channel: combinational read by PC, plus a serial
// MSB-first loader that rewrites the whole program while the executor reads zeros.
module ppwm_prog_mem #(
  parameter int unsigned INSTR_WIDTH = 7,
  parameter int unsigned PC_WIDTH    = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load_en_i,
  input  logic                   load_valid_i,
  input  logic                   load_bit_i,
  input  logic [PC_WIDTH-1:0]    pc_i,
  output logic [INSTR_WIDTH-1:0] instr_o,
  output logic                   busy_o,
  output logic                   load_done_o
);

  localparam int unsigned DEPTH = 2 ** PC_WIDTH;
  localparam int unsigned CNT_W = (INSTR_WIDTH > 1) ? $clog2(INSTR_WIDTH) : 1;

  typedef enum logic {
    StRun  = 1'b0,
    StLoad = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [INSTR_WIDTH-1:0] mem [DEPTH];
  logic [INSTR_WIDTH-1:0] shift_q;
  logic [CNT_W-1:0]       bit_cnt_q;
  logic [PC_WIDTH-1:0]    wptr_q;
  logic                   done_q;

  logic                   load_start;
  logic                   load_abort;
  logic                   shift_en;
  logic                   word_wr;
  logic [INSTR_WIDTH-1:0] word_next;

  assign word_next   = {shift_q[INSTR_WIDTH-2:0], load_bit_i};
  assign load_done_o = done_q;

  always_comb begin
    state_d    = state_q;
    instr_o    = '0;
    busy_o     = 1'b0;
    load_start = 1'b0;
    load_abort = 1'b0;
    shift_en   = 1'b0;
    word_wr    = 1'b0;
    case (state_q)
      StRun: begin
        instr_o = mem[pc_i];
        if (load_en_i) begin
          state_d    = StLoad;
          load_start = 1'b1;
        end
      end
      StLoad: begin
        busy_o = 1'b1;
        if (!load_en_i) begin
          state_d    = StRun;
          load_abort = 1'b1;
        end else if (load_valid_i) begin
          shift_en = 1'b1;
          word_wr  = (bit_cnt_q == CNT_W'(INSTR_WIDTH - 1));
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StRun;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      wptr_q    <= '0;
      done_q    <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      state_q <= state_d;
      if (load_start) begin
        bit_cnt_q <= '0;
        wptr_q    <= '0;
        done_q    <= 1'b0;
      end
      // Leaving load mode drops a partial word; wptr and done are kept.
      if (load_abort) bit_cnt_q <= '0;
      if (shift_en) begin
        shift_q <= word_next;
        if (word_wr) begin
          mem[wptr_q] <= word_next;
          bit_cnt_q   <= '0;
          wptr_q      <= wptr_q + 1'b1;
          if (wptr_q == '1) done_q <= 1'b1;
        end else begin
          bit_cnt_q <= bit_cnt_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ppwm_prog_mem.sv
// Directed bench for ppwm_prog_mem; expected values queue up as stimulus is
// driven and are popped when the DUT output is sampled.
module tb_ppwm_prog_mem;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load_en_i = 1'b0;
  logic       load_valid_i = 1'b0;
  logic       load_bit_i = 1'b0;
  logic [3:0] pc_i = '0;
  logic [6:0] instr_o;
  logic       busy_o;
  logic       load_done_o;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  ppwm_prog_mem #(.INSTR_WIDTH(7), .PC_WIDTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_en_i    (load_en_i),
    .load_valid_i (load_valid_i),
    .load_bit_i   (load_bit_i),
    .pc_i         (pc_i),
    .instr_o      (instr_o),
    .busy_o       (busy_o),
    .load_done_o  (load_done_o)
  );

  always #5 clk = ~clk;

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    n_assert++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %0h, required an expected entry", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    load_valid_i = 1'b1;
    load_bit_i   = b;
    tick();
    load_valid_i = 1'b0;
  endtask

  task automatic send_word(input logic [6:0] w);
    for (int i = 6; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic rd(input string tag, input logic [3:0] a, input logic [6:0] e);
    pc_i = a;
    push(tag, 32'(e));
    #1;
    chk(32'(instr_o));
  endtask

  task automatic enter_load();
    load_en_i = 1'b1;
    tick();
    push("busy_on_entry", 32'd1);
    chk(32'(busy_o));
  endtask

  task automatic exit_load();
    load_en_i = 1'b0;
    tick();
    push("busy_off_exit", 32'd0);
    chk(32'(busy_o));
  endtask

  initial begin
    logic [6:0] w;

    // Reset values, sampled while reset is held
    #2;
    for (int a = 0; a < 16; a++) rd("reset_instr", 4'(a), 7'h00);
    push("reset_busy", 32'd0); chk(32'(busy_o));
    push("reset_done", 32'd0); chk(32'(load_done_o));
    tick();
    rst_n = 1'b1;
    tick();

    // Full load: words = address + 1
    enter_load();
    for (int a = 0; a < 15; a++) send_word(7'(a + 1));
    push("done_before_last_word", 32'd0); chk(32'(load_done_o));
    w = 7'h10;
    for (int i = 6; i >= 1; i--) send_bit(w[i]);
    push("done_before_bit112", 32'd0); chk(32'(load_done_o));
    send_bit(w[0]);
    push("done_at_bit112", 32'd1); chk(32'(load_done_o));
    rd("instr_zero_while_busy", 4'd5, 7'h00);
    exit_load();
    rd("full_pc5", 4'd5, 7'h06);
    rd("full_pc0", 4'd0, 7'h01);
    rd("full_pc15", 4'd15, 7'h10);
    push("done_sticky_after_exit", 32'd1); chk(32'(load_done_o));

    // Gapped bits; a bit offered on the entry cycle must be dropped
    load_en_i    = 1'b1;
    load_valid_i = 1'b1;
    load_bit_i   = 1'b1;
    tick();
    load_valid_i = 1'b0;
    push("busy_gapped_entry", 32'd1); chk(32'(busy_o));
    push("done_cleared_on_entry", 32'd0); chk(32'(load_done_o));
    w = 7'h55;
    for (int i = 6; i >= 0; i--) begin
      send_bit(w[i]);
      tick();
    end
    exit_load();
    rd("gapped_mem0", 4'd0, 7'h55);
    rd("gapped_mem1_old", 4'd1, 7'h02);

    // Abort mid-word, then re-enter and write one word
    enter_load();
    send_word(7'h11);
    send_word(7'h22);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    exit_load();
    push("abort_done_low", 32'd0); chk(32'(load_done_o));
    rd("abort_mem2_kept", 4'd2, 7'h03);
    enter_load();
    send_word(7'h7F);
    exit_load();
    push("abort_done_still_low", 32'd0); chk(32'(load_done_o));
    rd("abort_mem0", 4'd0, 7'h7F);
    rd("abort_mem1", 4'd1, 7'h22);
    rd("abort_mem2", 4'd2, 7'h03);

    // Wrap: 17 words, the 17th overwrites address 0
    enter_load();
    for (int a = 0; a < 16; a++) send_word(7'(8'h30 + a));
    push("wrap_done_16", 32'd1); chk(32'(load_done_o));
    send_word(7'h2A);
    push("wrap_done_17", 32'd1); chk(32'(load_done_o));
    exit_load();
    rd("wrap_mem0", 4'd0, 7'h2A);
    rd("wrap_mem1", 4'd1, 7'h31);
    rd("wrap_mem15", 4'd15, 7'h3F);

    // Async reset mid-load, between clock edges
    enter_load();
    for (int a = 0; a < 8; a++) send_word(7'(a + 9));
    #2;
    rst_n = 1'b0;
    #1;
    push("async_busy_low", 32'd0); chk(32'(busy_o));
    push("async_done_low", 32'd0); chk(32'(load_done_o));
    load_en_i = 1'b0;
    for (int a = 0; a < 16; a++) rd("async_instr", 4'(a), 7'h00);
    tick();
    rst_n = 1'b1;
    tick();
    rd("post_reset_mem0", 4'd0, 7'h00);
    rd("post_reset_mem9", 4'd9, 7'h00);

    if (sb.size() != 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL scoreboard_leftover: observed %0d entries, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ppwm_prog_mem.md
# ppwm_prog_mem

Program store for one PWM channel's instruction executor. It holds `2**PC_WIDTH` instruction words and returns the word addressed by the executor's program counter, combinationally. A serial, bit-per-cycle loader lets the host write a complete program MSB-first. While a load is in progress, the executor sees all-zero instruction words.

## Interface

Parameters:
- `INSTR_WIDTH`, default 7: instruction word width in bits.
- `PC_WIDTH`, default 4: address width. Depth is `DEPTH = 2**PC_WIDTH` (derived, not overridable).

Ports:
- `clk`  input  1: single clock; all state updates on the rising edge.
- `rst_n`  input  1: asynchronous, active-low reset.
- `load_en_i`  input  1: host requests load mode; level-sensitive.
- `load_valid_i`  input  1: `load_bit_i` carries a valid bit this cycle.
- `load_bit_i`  input  1: serial program data, MSB of each word first.
- `pc_i`  input  PC_WIDTH: read address from the executor.
- `instr_o`  output  INSTR_WIDTH: instruction word at `pc_i`.
- `busy_o`  output  1: high while in load mode.
- `load_done_o`  output  1: sticky flag; all DEPTH words written since the last load start.

## Operation

Reset (asynchronous, `rst_n` = 0):
- All memory words = 0.
- State = `StRun`.
- Shift register, `bit_cnt` and `wptr` = 0.
- `busy_o` = 0, `load_done_o` = 0.
- `instr_o` = 0, because every memory word is 0.

FSM, two states:
- `StRun`
  - `instr_o = mem[pc_i]`.
  - `load_valid_i` and `load_bit_i` are ignored.
  - If `load_en_i` = 1: next state `StLoad`. On the same edge, clear `bit_cnt`, `wptr` and `load_done_o`.
- `StLoad`
  - `instr_o` = 0 and `busy_o` = 1.
  - If `load_en_i` = 0: next state `StRun`. Clear `bit_cnt`, which discards any partial word. `wptr` and `load_done_o` keep their values. `load_valid_i` in this cycle is ignored.
  - Otherwise, on each cycle with `load_valid_i` = 1:
    - `shift_q <= {shift_q[INSTR_WIDTH-2:0], load_bit_i}`.
    - `bit_cnt` increments.
  - When `bit_cnt == INSTR_WIDTH-1` and `load_valid_i` = 1, on that edge:
    - `mem[wptr] <= {shift_q[INSTR_WIDTH-2:0], load_bit_i}`.
    - `bit_cnt <= 0`.
    - `wptr <= wptr + 1`, modulo DEPTH.
  - When that write has `wptr == DEPTH-1`, set `load_done_o` <= 1. Any further words wrap and overwrite from address 0; `load_done_o` stays 1.
- Any illegal state encoding goes to `StRun`.

Width rules:
- `bit_cnt` is `$clog2(INSTR_WIDTH)` bits wide.
- `wptr` is PC_WIDTH bits wide and wraps naturally.
- The read path has no registers: `pc_i` to `instr_o` is purely combinational.

## Timing

- Read latency is 0 cycles: `instr_o` follows `pc_i` in the same cycle while in `StRun`.
- Load entry takes 1 cycle. `busy_o` rises on the first edge where `load_en_i` = 1. A bit presented in that same cycle is dropped. The host must start bits on the cycle after `busy_o` = 1.
- Bits may have gaps: cycles with `load_valid_i` = 0 hold all state.
- A word becomes written on the edge that samples its last bit. It is visible on `instr_o` only after returning to `StRun`.
- Load exit takes 1 cycle. `busy_o` falls on the first edge where `load_en_i` = 0. Reads return memory contents from the following cycle.
- `load_done_o` rises on the edge that writes address DEPTH-1. It clears only on the next load entry or on reset.
- Reset asserted mid-load aborts immediately. Memory is cleared, so a partial program never survives reset.

## Test plan

- **Reset values:** assert `rst_n` = 0, sweep `pc_i` 0..15 → `instr_o` = 0, `busy_o` = 0, `load_done_o` = 0.
- **Full load:**
  - Stimulus: raise `load_en_i`, wait 1 cycle, shift 16 words MSB-first with words = address+1 (7'h01..7'h10), then drop `load_en_i`.
  - Required: `load_done_o` = 1 on the edge of the 112th bit; `instr_o` = 0 while `busy_o` = 1; after exit, `pc_i` = 5 → `instr_o` = 7'h06.
- **Gapped bits:** shift word 7'h55 with `load_valid_i` toggling 1/0 each cycle → `mem[0]` = 7'h55. A bit sent on the same cycle `load_en_i` rises is ignored.
- **Abort mid-word:**
  - Stimulus: after 2 full words, send 3 bits, drop `load_en_i`; re-enter load, write 1 word 7'h7F.
  - Required: `load_done_o` = 0 throughout; `mem[0]` = 7'h7F; `mem[1]` keeps its old value; `mem[2]` unchanged from before the aborted load.
- **Wrap:** load 17 words with word 16 = 7'h2A → `load_done_o` = 1; `mem[0]` = 7'h2A.
- **Async reset mid-load:** pulse `rst_n` low between clock edges after 8 words → `busy_o` = 0 immediately; all `instr_o` reads = 0.
